// File: rtl/mem_sp_init.sv
// ============================================================================
// Module  : mem_sp_init
// Brief   : Single-port sync RAM, post-reset zeroing sweep, registered read.
//           Optional per-word parity via `MEM_PARITY_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sp_init #(
    parameter int A_HEIGHT = 4,
    parameter int D_WIDTH  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd,
    input  logic                wr,
    input  logic [A_HEIGHT-1:0] addr,
    input  logic [D_WIDTH-1:0]  din,
    input  logic                inj_perr,
    output logic [D_WIDTH-1:0]  dout,
    output logic                dout_vld,
    output logic                busy,
    output logic                perr
);

    localparam int DEPTH = 2 ** A_HEIGHT;
    localparam logic [A_HEIGHT:0] c_LAST = (A_HEIGHT + 1)'(DEPTH - 1);

`ifdef MEM_PARITY_EN
    localparam int MW = D_WIDTH + 1;
`else
    localparam int MW = D_WIDTH;
`endif

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t              r_state;
    logic [A_HEIGHT:0]   r_init_cnt;
    logic [D_WIDTH-1:0]  r_dout;
    logic                r_dout_vld;
    logic                r_busy;
    logic                r_perr;
    logic [MW-1:0]       r_mem [DEPTH];

    logic                w_mem_we;
    logic [A_HEIGHT-1:0] w_mem_addr;
    logic [MW-1:0]       w_mem_wdata;
    logic [MW-1:0]       w_wr_word;
    logic                w_acc_ok;

`ifdef MEM_PARITY_EN
    assign w_wr_word = {(^din) ^ inj_perr, din};
`else
    logic w_unused_inj;
    assign w_unused_inj = inj_perr;
    assign w_wr_word    = din;
`endif

    assign w_acc_ok    = (r_state == ST_IDLE);
    assign w_mem_we    = (r_state == ST_INIT) || (w_acc_ok && wr);
    assign w_mem_addr  = (r_state == ST_INIT) ? r_init_cnt[A_HEIGHT-1:0] : addr;
    assign w_mem_wdata = (r_state == ST_INIT) ? '0 : w_wr_word;

    // Storage is deliberately not reset; the sweep clears it after release.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_busy     <= 1'b1;
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_dout_vld <= 1'b0;
            r_perr     <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == c_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // Reads see the pre-edge contents, giving read-before-write.
                    if (rd) begin
                        r_dout     <= r_mem[addr][D_WIDTH-1:0];
                        r_dout_vld <= 1'b1;
`ifdef MEM_PARITY_EN
                        r_perr     <= ^r_mem[addr];
`endif
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign busy     = r_busy;
`ifdef MEM_PARITY_EN
    assign perr     = r_perr;
`else
    logic w_unused_perr;
    assign w_unused_perr = r_perr;
    assign perr          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_sp_init.sv
// ============================================================================
// Module  : tb_mem_sp_init
// Brief   : Directed self-checking bench for mem_sp_init (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_sp_init;

    logic       clk;
    logic       rst_n;
    logic       rd;
    logic       wr;
    logic [3:0] addr;
    logic [3:0] din;
    logic       inj_perr;
    logic [3:0] dout;
    logic       dout_vld;
    logic       busy;
    logic       perr;

    int total = 0;
    int bad   = 0;

    mem_sp_init #(.A_HEIGHT(4), .D_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd       (rd),
        .wr       (wr),
        .addr     (addr),
        .din      (din),
        .inj_perr (inj_perr),
        .dout     (dout),
        .dout_vld (dout_vld),
        .busy     (busy),
        .perr     (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk({tag, "_busy"}, 32'(busy), (i < 16) ? 32'd1 : 32'd0);
            chk({tag, "_vld"}, 32'(dout_vld), 32'd0);
            if (i == 16) begin
                rd = 1'b0;
                wr = 1'b0;
            end
        end
    endtask

    initial begin
        logic exp_perr;
`ifdef MEM_PARITY_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0; inj_perr = 1'b0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_vld",  32'(dout_vld), 32'd0);
        chk("rst_perr", 32'(perr), 32'd0);

        // Release; requests during the sweep must be ignored.
        rst_n = 1'b1;
        wr = 1'b1; rd = 1'b1; addr = 4'd3; din = 4'hF;
        sweep_check("sweep1");

        for (int a = 15; a >= 0; a--) begin
            addr = 4'(a); rd = 1'b1;
            tick();
            chk("clr_dout", 32'(dout), 32'd0);
            chk("clr_vld",  32'(dout_vld), 32'd1);
            rd = 1'b0;
            tick();
            chk("clr_vld_drop", 32'(dout_vld), 32'd0);
        end

        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); din = 4'(a); wr = 1'b1;
            tick();
        end
        wr = 1'b0;
        for (int a = 15; a >= 0; a--) begin
            addr = 4'(a); rd = 1'b1;
            tick();
            chk("b2b_dout", 32'(dout), 32'(a));
            chk("b2b_vld",  32'(dout_vld), 32'd1);
        end

        addr = 4'd5; din = 4'hA; rd = 1'b1; wr = 1'b1;
        tick();
        chk("rbw_old", 32'(dout), 32'd5);
        wr = 1'b0;
        tick();
        chk("rbw_new", 32'(dout), 32'hA);
        chk("rbw_vld", 32'(dout_vld), 32'd1);

        rd = 1'b0; wr = 1'b1; addr = 4'd7; din = 4'hC;
        tick();
        wr = 1'b0; rd = 1'b1;
        tick();
        chk("wtr_dout", 32'(dout), 32'hC);
        rd = 1'b0;
        tick();
        chk("hold_vld",  32'(dout_vld), 32'd0);
        chk("hold_dout", 32'(dout), 32'hC);

        wr = 1'b1; addr = 4'd2; din = 4'd6; inj_perr = 1'b1;
        tick();
        wr = 1'b0; inj_perr = 1'b0; rd = 1'b1;
        tick();
        chk("par_dout", 32'(dout), 32'd6);
        chk("par_perr", 32'(perr), 32'(exp_perr));
        rd = 1'b0;
        tick();
        chk("par_perr_idle", 32'(perr), 32'd0);
        wr = 1'b1;
        tick();
        wr = 1'b0; rd = 1'b1;
        tick();
        chk("par_clean_dout", 32'(dout), 32'd6);
        chk("par_clean_perr", 32'(perr), 32'd0);

        // Reset with a read result on the outputs clears them at once.
        addr = 4'd9; rd = 1'b1;
        tick();
        chk("prerst_vld", 32'(dout_vld), 32'd1);
        chk("prerst_dout", 32'(dout), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_vld",  32'(dout_vld), 32'd0);
        chk("async_dout", 32'(dout), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        rd = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sweep_check("sweep2");

        for (int a = 0; a < 16; a += 5) begin
            addr = 4'(a); rd = 1'b1;
            tick();
            chk("reclr_dout", 32'(dout), 32'd0);
            chk("reclr_vld",  32'(dout_vld), 32'd1);
        end
        rd = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
